// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage MIPS core.
// Drives PC write, IF/ID enable/flush and the ID/EX bubble. It resolves
// load-use hazards, taken branches, jumps, instruction-memory wait states
// and mult/div occupancy. It also keeps a saturating stall-cycle counter.
//
//   state      | meaning
//   -----------+----------------------------------------------------------
//   ST_RUN     | normal issue; hazards are resolved per cycle by priority
//   ST_MD_BUSY | mult/div occupying EX; front end held, bubbles issued
module pipeline_hazard_ctrl #(
    parameter int MD_LATENCY = 8,
    parameter int CNT_W      = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ID_rs,
    input  logic [4:0]  ID_rt,
    input  logic        ID_rt_used,
    input  logic        ID_jump,
    input  logic        ID_md_start,
    input  logic        EX_MemRead,
    input  logic [4:0]  EX_rt,
    input  logic        EX_branch_taken,
    input  logic        imem_ready,
    output logic        PC_write,
    output logic        IFID_write,
    output logic        IFID_flush,
    output logic        IDEX_bubble,
    output logic        md_busy,
    output logic [15:0] stall_cycles
);

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_MD_BUSY = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   md_cnt_q, md_cnt_d;
    logic               md_busy_q, md_busy_d;
    logic [15:0]        stall_q, stall_d;
    logic               load_use;
    logic               pc_write_c, ifid_write_c, ifid_flush_c, idex_bubble_c;

    // Load in EX whose destination feeds a source of the ID instruction.
    always_comb begin
        load_use = EX_MemRead && (EX_rt != 5'd0) &&
                   ((EX_rt == ID_rs) || (ID_rt_used && (EX_rt == ID_rt)));
    end

    // Next-state and per-cycle pipeline control, highest-priority hazard first.
    always_comb begin
        state_d       = state_q;
        md_cnt_d      = md_cnt_q;
        pc_write_c    = 1'b1;
        ifid_write_c  = 1'b1;
        ifid_flush_c  = 1'b0;
        idex_bubble_c = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (EX_branch_taken) begin
                    ifid_flush_c  = 1'b1;
                    idex_bubble_c = 1'b1;
                end else if (load_use) begin
                    // md_start is deliberately ignored here; the transition
                    // happens once the stall has cleared.
                    pc_write_c    = 1'b0;
                    ifid_write_c  = 1'b0;
                    idex_bubble_c = 1'b1;
                end else if (ID_jump) begin
                    ifid_flush_c  = 1'b1;
                end else begin
                    if (!imem_ready) begin
                        pc_write_c   = 1'b0;
                        ifid_flush_c = 1'b1;
                    end
                    if (ID_md_start) begin
                        state_d  = ST_MD_BUSY;
                        md_cnt_d = CNT_W'(MD_LATENCY - 1);
                    end
                end
            end
            ST_MD_BUSY: begin
                if (EX_branch_taken) begin
                    // Should not happen (EX holds a bubble); recover to RUN.
                    ifid_flush_c  = 1'b1;
                    idex_bubble_c = 1'b1;
                    state_d       = ST_RUN;
                    md_cnt_d      = '0;
                end else begin
                    pc_write_c    = 1'b0;
                    ifid_write_c  = 1'b0;
                    idex_bubble_c = 1'b1;
                    md_cnt_d      = md_cnt_q - CNT_W'(1);
                    if (md_cnt_q <= CNT_W'(1)) begin
                        state_d  = ST_RUN;
                        md_cnt_d = '0;
                    end
                end
            end
            default: begin
                state_d  = ST_RUN;
                md_cnt_d = '0;
            end
        endcase
    end

    // Registered status: busy flag follows the next state, stall counter saturates.
    always_comb begin
        md_busy_d = (state_d == ST_MD_BUSY);
        stall_d   = stall_q;
        if (!pc_write_c && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    // Reset overrides the combinational outputs so the pipeline is held flushed.
    always_comb begin
        if (!rst) begin
            PC_write    = 1'b0;
            IFID_write  = 1'b1;
            IFID_flush  = 1'b1;
            IDEX_bubble = 1'b1;
        end else begin
            PC_write    = pc_write_c;
            IFID_write  = ifid_write_c;
            IFID_flush  = ifid_flush_c;
            IDEX_bubble = idex_bubble_c;
        end
    end

    // State, counter and status registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_RUN;
            md_cnt_q  <= '0;
            md_busy_q <= 1'b0;
            stall_q   <= '0;
        end else begin
            state_q   <= state_d;
            md_cnt_q  <= md_cnt_d;
            md_busy_q <= md_busy_d;
            stall_q   <= stall_d;
        end
    end

    assign md_busy      = md_busy_q;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with hand-computed expectations.
module tb_pipeline_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic [4:0]  ID_rs, ID_rt, EX_rt;
    logic        ID_rt_used, ID_jump, ID_md_start;
    logic        EX_MemRead, EX_branch_taken, imem_ready;
    logic        PC_write, IFID_write, IFID_flush, IDEX_bubble, md_busy;
    logic [15:0] stall_cycles;

    int n_total = 0;
    int n_bad   = 0;

    pipeline_hazard_ctrl #(.MD_LATENCY(8), .CNT_W(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .ID_rs           (ID_rs),
        .ID_rt           (ID_rt),
        .ID_rt_used      (ID_rt_used),
        .ID_jump         (ID_jump),
        .ID_md_start     (ID_md_start),
        .EX_MemRead      (EX_MemRead),
        .EX_rt           (EX_rt),
        .EX_branch_taken (EX_branch_taken),
        .imem_ready      (imem_ready),
        .PC_write        (PC_write),
        .IFID_write      (IFID_write),
        .IFID_flush      (IFID_flush),
        .IDEX_bubble     (IDEX_bubble),
        .md_busy         (md_busy),
        .stall_cycles    (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // PC_write, IFID_write, IFID_flush, IDEX_bubble packed as a nibble.
    task automatic check_ctl(input string tag, input logic [3:0] exp);
        check_val(tag, {12'd0, PC_write, IFID_write, IFID_flush, IDEX_bubble}, {12'd0, exp});
    endtask

    task automatic set_idle();
        ID_rs = 5'd0; ID_rt = 5'd0; EX_rt = 5'd0;
        ID_rt_used = 1'b0; ID_jump = 1'b0; ID_md_start = 1'b0;
        EX_MemRead = 1'b0; EX_branch_taken = 1'b0; imem_ready = 1'b1;
    endtask

    // Advance one edge; inputs change 1 unit after posedge, checks 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        set_idle();
        #2;
        check_ctl("rst_ctl", 4'b0111);
        check_val("rst_busy", {15'd0, md_busy}, 16'd0);
        check_val("rst_stall", stall_cycles, 16'd0);
        tick();
        check_val("rst_clk_stall", stall_cycles, 16'd0);
        rst = 1'b1;
        #1;
        check_ctl("run_normal", 4'b1100);

        // load-use on rs
        EX_MemRead = 1'b1; EX_rt = 5'd5; ID_rs = 5'd5;
        #1 check_ctl("lu_rs", 4'b0001);
        tick();
        EX_MemRead = 1'b0;
        #1 check_ctl("lu_after", 4'b1100);
        check_val("lu_stall1", stall_cycles, 16'd1);

        // EX_rt = 0 never hazards
        EX_MemRead = 1'b1; EX_rt = 5'd0; ID_rs = 5'd0;
        #1 check_ctl("lu_r0", 4'b1100);
        tick();
        check_val("lu_r0_stall", stall_cycles, 16'd1);

        // rt match only counts when rt is a source
        EX_rt = 5'd7; ID_rs = 5'd3; ID_rt = 5'd7; ID_rt_used = 1'b0;
        #1 check_ctl("lu_rt_unused", 4'b1100);
        ID_rt_used = 1'b1;
        #1 check_ctl("lu_rt_used", 4'b0001);
        tick();
        set_idle();
        #1 check_val("lu_rt_stall", stall_cycles, 16'd2);

        // taken branch outranks load-use
        EX_branch_taken = 1'b1; EX_MemRead = 1'b1; EX_rt = 5'd5; ID_rs = 5'd5;
        #1 check_ctl("br_over_lu", 4'b1111);
        tick();
        set_idle();
        #1 check_val("br_stall", stall_cycles, 16'd2);

        // load-use beats imem wait: hold, no flush
        EX_MemRead = 1'b1; EX_rt = 5'd9; ID_rs = 5'd9; imem_ready = 1'b0;
        #1 check_ctl("lu_over_imem", 4'b0001);
        tick();
        set_idle();
        #1 check_val("lu_imem_stall", stall_cycles, 16'd3);

        // md_start with load-use: stall first, then transition
        ID_md_start = 1'b1; EX_MemRead = 1'b1; EX_rt = 5'd4; ID_rs = 5'd4;
        #1 check_ctl("md_lu", 4'b0001);
        tick();
        check_val("md_lu_nobusy", {15'd0, md_busy}, 16'd0);
        EX_MemRead = 1'b0;
        #1 check_ctl("md_issue", 4'b1100);
        tick();
        ID_md_start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            #1;
            check_val($sformatf("md_busy_%0d", i), {15'd0, md_busy}, 16'd1);
            check_ctl($sformatf("md_ctl_%0d", i), 4'b0001);
            tick();
        end
        #1 check_val("md_done_busy", {15'd0, md_busy}, 16'd0);
        check_ctl("md_done_ctl", 4'b1100);
        check_val("md_stall", stall_cycles, 16'd11);

        // imem wait for 3 cycles, jump during the middle one
        imem_ready = 1'b0;
        #1 check_ctl("imem_w0", 4'b0110);
        tick();
        ID_jump = 1'b1;
        #1 check_ctl("imem_jump", 4'b1110);
        tick();
        ID_jump = 1'b0;
        #1 check_ctl("imem_w2", 4'b0110);
        tick();
        set_idle();
        #1 check_val("imem_stall", stall_cycles, 16'd13);

        // branch while mult/div busy recovers to RUN
        ID_md_start = 1'b1;
        tick();
        ID_md_start = 1'b0;
        #1 check_val("mdbr_busy", {15'd0, md_busy}, 16'd1);
        tick();
        EX_branch_taken = 1'b1;
        #1 check_ctl("mdbr_ctl", 4'b1111);
        tick();
        EX_branch_taken = 1'b0;
        #1 check_val("mdbr_busy_off", {15'd0, md_busy}, 16'd0);
        check_ctl("mdbr_run", 4'b1100);
        check_val("mdbr_stall", stall_cycles, 16'd14);

        // asynchronous reset mid mult/div
        ID_md_start = 1'b1;
        tick();
        ID_md_start = 1'b0;
        tick();
        #1 rst = 1'b0;
        #1;
        check_ctl("arst_ctl", 4'b0111);
        check_val("arst_busy", {15'd0, md_busy}, 16'd0);
        check_val("arst_stall", stall_cycles, 16'd0);
        rst = 1'b1;
        #1 check_ctl("arst_run", 4'b1100);
        tick();
        check_val("arst_busy2", {15'd0, md_busy}, 16'd0);
        check_val("arst_stall2", stall_cycles, 16'd0);

        // saturation
        imem_ready = 1'b0;
        for (int i = 0; i < 65540; i++) tick();
        check_val("sat_stall", stall_cycles, 16'hFFFF);
        tick();
        check_val("sat_hold", stall_cycles, 16'hFFFF);
        set_idle();
        tick();
        check_val("sat_final", stall_cycles, 16'hFFFF);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Pipeline sequencing controller for the 5-stage MIPS core. It drives the enable and flush of the IF/ID pipeline register, the PC write enable and the ID/EX bubble. It resolves load-use hazards, taken branches and jumps, instruction-memory wait states, and multi-cycle multiply/divide occupancy. It sits beside the IF/ID register and the hazard-relevant fields of ID and EX, and keeps a stall-cycle performance counter.

## Interface
- MD_LATENCY, default 8: cycles the mult/div unit is busy after issue (≥2).
- CNT_W, default 4: width of the mult/div down-counter (must hold MD_LATENCY-1).
- clk  in  1  rising-edge clock.
- rst  in  1  reset; asynchronous, active-low (asserted when 0).
- ID_rs  in  5  rs field of instruction in ID.
- ID_rt  in  5  rt field of instruction in ID.
- ID_rt_used  in  1  ID instruction reads rt as a source.
- ID_jump  in  1  ID holds j/jal/jr (target resolved in ID).
- ID_md_start  in  1  ID holds mult/multu/div/divu.
- EX_MemRead  in  1  EX holds a load.
- EX_rt  in  5  destination register of the EX load.
- EX_branch_taken  in  1  branch in EX resolved taken.
- imem_ready  in  1  instruction memory returns valid data this cycle.
- PC_write  out  1  PC register load enable.
- IFID_write  out  1  IF/ID register load enable (0 = hold).
- IFID_flush  out  1  IF/ID loads NOP (instruction 0) instead of IF_inst.
- IDEX_bubble  out  1  ID/EX loads control zeros.
- md_busy  out  1  registered; mult/div in progress.
- stall_cycles  out  16  registered; saturating count of cycles with PC_write=0.

## Operation
- FSM states: RUN, MD_BUSY. Down-counter md_cnt[CNT_W-1:0].
- load_use = EX_MemRead & (EX_rt≠0) & (EX_rt==ID_rs | (ID_rt_used & EX_rt==ID_rt)).
- Outputs in RUN are evaluated in priority order:
  1. EX_branch_taken: PC_write=1, IFID_write=1, IFID_flush=1, IDEX_bubble=1.
  2. load_use: PC_write=0, IFID_write=0, IFID_flush=0, IDEX_bubble=1.
  3. ID_jump: PC_write=1, IFID_write=1, IFID_flush=1, IDEX_bubble=0. This applies regardless of imem_ready.
  4. !imem_ready: PC_write=0, IFID_write=1, IFID_flush=1, IDEX_bubble=0.
  5. Otherwise: PC_write=1, IFID_write=1, IFID_flush=0, IDEX_bubble=0.
- RUN→MD_BUSY: on the edge where the final decision is case 5 or case 4 and ID_md_start=1. On that edge md_cnt←MD_LATENCY-1 and the mult/div instruction advances to EX.
- MD_BUSY outputs: PC_write=0, IFID_write=0, IFID_flush=0, IDEX_bubble=1, md_busy=1.
- In MD_BUSY, md_cnt decrements each cycle. When md_cnt==1 the next state is RUN, giving exactly MD_LATENCY-1 MD_BUSY cycles.
- EX_branch_taken in MD_BUSY is illegal (EX holds a bubble). If it occurs anyway: branch outputs apply, next state is RUN, md_cnt←0.
- stall_cycles increments on every edge where PC_write=0 and saturates at 16'hFFFF.

## Timing
- PC_write, IFID_write, IFID_flush and IDEX_bubble are combinational from state and inputs, valid in the same cycle.
- md_busy and stall_cycles are registered with 1-cycle latency.
- While rst=0, regardless of clk: state=RUN, md_cnt=0, md_busy=0, stall_cycles=0, PC_write=0, IFID_write=1, IFID_flush=1, IDEX_bubble=1.
- Reset asserted mid-MD_BUSY aborts immediately; the first edge after release operates from RUN.
- A load-use stall lasts exactly 1 cycle: the load leaves EX and the bubble enters, so load_use drops.
- Simultaneous load_use and !imem_ready: load_use wins, IF/ID is held and not flushed.
- ID_md_start together with load_use: the stall is taken first, and the transition happens the following cycle.

## Test plan
- Load-use: EX_MemRead=1, EX_rt=5, ID_rs=5 → one cycle with PC_write=0, IFID_write=0, IDEX_bubble=1. Next cycle is normal and stall_cycles=1. Repeat with EX_rt=0 → no stall.
- Taken branch with load_use also true → IFID_flush=1, IDEX_bubble=1, PC_write=1, no stall counted.
- ID_md_start=1, MD_LATENCY=8 → md_busy=1 for exactly 7 cycles, then RUN resumes and stall_cycles=7.
- imem_ready=0 for 3 cycles → PC_write=0 and IFID_flush=1 each cycle. ID_jump=1 during the wait → PC_write=1.
- rst driven low mid-MD_BUSY (async, between edges) → outputs at reset values immediately. After release the FSM is in RUN and stall_cycles=0.
- Force 65540 stall cycles → stall_cycles holds 16'hFFFF.
